adder_result_stage: RTL and testbench
=====================================

Name: adder_result_stage

Overview:
- Registered output stage placed directly downstream of the 32-bit adder (thirty-two-bit ripple adder built from two 16-bit halves).
- Captures the adder sum and carry-out together with the operand sign bits.
- Derives status flags and optionally saturates the result on signed overflow.
- Presents results to the consumer through a valid/ready interface, backed by a 2-entry skid buffer and a signed-overflow event counter.

Parameters:
- WIDTH, 32: data width of the sum and result.
- CNT_W, 16: width of the overflow event counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream adder result is valid this cycle.
- in_ready  output  1  stage can accept an input this cycle.
- sum  input  WIDTH  S output of the adder.
- cout  input  1  Cout of the adder.
- a_msb  input  1  bit WIDTH-1 of operand A as presented to the adder.
- b_msb  input  1  bit WIDTH-1 of operand B as presented to the adder (post-inversion for subtract).
- sat_en  input  1  saturate on signed overflow; sampled with the input transaction.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  final (possibly saturated) result.
- flag_c  output  1  carry.
- flag_z  output  1  zero.
- flag_n  output  1  negative.
- flag_v  output  1  signed overflow.
- ovf_count  output  CNT_W  number of accepted transactions with V=1.
- cnt_clr  input  1  synchronous clear of ovf_count.

Behaviour:
- Clock and reset: one clock, clk. Reset (reset) is synchronous and active-high.
- Reset values: state EMPTY, out_valid=0, result=0, all flags 0, ovf_count=0.
- in_ready = (state != TWO) && !reset. It is combinational from the state register only; no combinational path from in_valid or out_ready.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Flag derivation, at input:
  - V = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb).
  - C = cout.
- Saturation: if sat_en && V, the stored result is 0x7FFFFFFF when a_msb=0 and 0x80000000 when a_msb=1. Otherwise the stored result is sum.
- Flags on the stored result: N = result[WIDTH-1] and Z = (result == 0), both computed on the stored (post-saturation) result. C and V are stored unchanged by saturation.
- Storage: head register (drives the outputs) plus skid register. Each entry holds {result, C, Z, N, V}. Delivery is FIFO order.
- States: EMPTY (0 entries), ONE (head valid), TWO (head + skid valid). out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: push -> ONE, data into head.
  - ONE: push && !pop -> TWO, data into skid.
  - ONE: push && pop -> ONE, new data into head.
  - ONE: !push && pop -> EMPTY.
  - TWO: pop -> ONE, skid moves to head. Push is impossible in TWO.
  - Any other case: hold.
- Latency: push in cycle t to an empty stage gives out_valid=1 with that data in cycle t+1. Throughput is 1 per cycle when out_ready stays high.
- Output stability: while out_valid && !out_ready, result and flags hold stable.
- Overflow counter:
  - ovf_count increments by 1 on each push with V=1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority: a clear in the same cycle as an overflow push yields 0, and that event is not counted.
- Reset mid-operation: all buffered entries are discarded. out_valid=0 in the cycle after reset is sampled. in_ready=0 while reset is high.
- Inputs other than cnt_clr are ignored when no push occurs.

Test Plan:
- Basic: push sum=0x00000005, cout=0, a_msb=0, b_msb=0 into an empty stage with out_ready=1 -> next cycle out_valid=1, result=5, C=0, Z=0, N=0, V=0; one cycle later out_valid=0.
- Overflow + saturation: a_msb=0, b_msb=0, sum=0x80000000, sat_en=1 -> result=0x7FFFFFFF, V=1, N=0, ovf_count=1. Repeat with a_msb=1, b_msb=1, sum=0x00000000, cout=1, sat_en=1 -> result=0x80000000, C=1, V=1, Z=0, ovf_count=2. Same negative case with sat_en=0 -> result=0, Z=1.
- Backpressure: out_ready=0, push A=0x11 then B=0x22 -> in_ready=0 in the cycle after the second push, third input ignored. Then out_ready=1 -> 0x11 then 0x22 delivered on consecutive cycles, in_ready returns to 1.
- Simultaneous push/pop in ONE: head=0x33, push 0x44 with out_ready=1 -> next cycle head=0x44, state stays ONE, no entry lost or duplicated.
- Counter: preload ovf_count to 0xFFFF via overflow pushes -> further overflow pushes hold 0xFFFF. Assert cnt_clr together with an overflow push -> ovf_count=0.
- Reset mid-operation: in state TWO, assert reset for 1 cycle -> out_valid=0, in_ready=0 during reset, ovf_count=0. After release, in_ready=1 and a new push emerges with no stale data.

Source files
------------

// File: rtl/adder_result_stage.sv
// Registered result stage behind the 32-bit adder: derives C/Z/N/V, optionally
// saturates on signed overflow, and hands results out through a 2-entry skid buffer.
module adder_result_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             cnt_clr
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;
    localparam int EW = WIDTH + 4;

    // Clamp to the signed extreme matching the operand sign when overflow occurs.
    function automatic logic signed [WIDTH-1:0] saturate(
        input logic signed [WIDTH-1:0] s,
        input logic                    neg,
        input logic                    ovf,
        input logic                    en
    );
        if (en && ovf)
            return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                    v_p0;
    logic signed [WIDTH-1:0] res_p0;
    logic [EW-1:0]           entry_p0;
    logic [1:0]              state_p1;
    logic [EW-1:0]           head_p1;
    logic [EW-1:0]           skid_p1;
    logic                    vld_p1;
    logic                    push;
    logic                    pop;

    // p0: flag derivation and saturation on the incoming adder result
    assign v_p0     = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
    assign res_p0   = saturate($signed(sum), a_msb, v_p0, sat_en);
    assign entry_p0 = {res_p0, cout, (res_p0 == '0), res_p0[WIDTH-1], v_p0};

    assign vld_p1    = (state_p1 != S_EMPTY);
    assign out_valid = vld_p1;
    assign in_ready  = (state_p1 != S_TWO) && !reset;
    assign push      = in_valid && in_ready;
    assign pop       = vld_p1 && out_ready;

    assign result = head_p1[EW-1:4];
    assign flag_c = head_p1[3];
    assign flag_z = head_p1[2];
    assign flag_n = head_p1[1];
    assign flag_v = head_p1[0];

    // p1: head/skid storage; head is cleared so outputs read zero after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= S_EMPTY;
            head_p1  <= '0;
        end else begin
            case (state_p1)
                S_EMPTY: begin
                    if (push) begin
                        head_p1  <= entry_p0;
                        state_p1 <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_p1 <= entry_p0;
                    end else if (push) begin
                        state_p1 <= S_TWO;
                    end else if (pop) begin
                        state_p1 <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        head_p1  <= skid_p1;
                        state_p1 <= S_ONE;
                    end
                end
                default: state_p1 <= S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_p1 == S_ONE && push && !pop)
            skid_p1 <= entry_p0;
    end

    // Clear wins over a same-cycle overflow push.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr)
            ovf_count <= '0;
        else if (push && v_p0)
            ovf_count <= sat_inc(ovf_count);
    end

endmodule

// File: tb/tb_adder_result_stage.sv
// Bench for adder_result_stage: directed scenarios plus randomized operands
// checked against a queue-based model that computes overflow with signed arithmetic.
module tb_adder_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] sum;
    logic        cout;
    logic        a_msb;
    logic        b_msb;
    logic        sat_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_c, flag_z, flag_n, flag_v;
    logic [15:0] ovf_count;
    logic        cnt_clr;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } ent_t;

    ent_t mq[$];
    int   mcnt = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    adder_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .cout(cout), .a_msb(a_msb), .b_msb(b_msb), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .ovf_count(ovf_count), .cnt_clr(cnt_clr)
    );

    function automatic ent_t mk(input logic [31:0] r, input logic c, input logic v);
        ent_t e;
        e.r = r; e.c = c; e.v = v;
        e.z = (r == 32'd0);
        e.n = r[31];
        return e;
    endfunction

    // Drive one cycle of inputs and advance the model; returns #1 after the edge.
    task automatic step(input logic iv, input logic [31:0] s, input logic co,
                        input logic am, input logic bm, input logic se,
                        input logic ordy, input logic clr, input ent_t e);
        bit   mpush, mpop;
        ent_t d;
        in_valid = iv; sum = s; cout = co; a_msb = am; b_msb = bm;
        sat_en = se; out_ready = ordy; cnt_clr = clr;
        mpush = iv && (mq.size() < 2);
        mpop  = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (mpop) d = mq.pop_front();
        if (mpush) mq.push_back(e);
        if (clr) mcnt = 0;
        else if (mpush && e.v && mcnt < 65535) mcnt++;
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1, ordy, 1'b0, mk(32'd0, 1'b0, 1'b0));
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        sum = '0; cout = 1'b0; a_msb = 1'b0; b_msb = 1'b0; sat_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        tests_run++;
        if (result !== 32'd0 || {flag_c, flag_z, flag_n, flag_v} !== 4'b0000 || ovf_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_data: result=%h flags=%b cnt=%0d expected 0", result,
                     {flag_c, flag_z, flag_n, flag_v}, ovf_count);
        end
        reset = 1'b0;
        mq.delete(); mcnt = 0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_basic;
        step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h5, 1'b0, 1'b0));
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'h5 || {flag_c, flag_z, flag_n, flag_v} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL basic: valid=%b result=%h flags=%b expected 1 5 0000", out_valid, result,
                     {flag_c, flag_z, flag_n, flag_v});
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_saturation;
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        tests_run++;
        if (result !== 32'h7FFF_FFFF || flag_v !== 1'b1 || flag_n !== 1'b0 || ovf_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL sat_pos: result=%h v=%b n=%b cnt=%0d expected 7fffffff 1 0 1", result, flag_v,
                     flag_n, ovf_count);
        end
        step(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, mk(32'h8000_0000, 1'b1, 1'b1));
        tests_run++;
        if (result !== 32'h8000_0000 || {flag_c, flag_z, flag_v} !== 3'b101 || ovf_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL sat_neg: result=%h czv=%b cnt=%0d expected 80000000 101 2", result,
                     {flag_c, flag_z, flag_v}, ovf_count);
        end
        step(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b1));
        tests_run++;
        if (result !== 32'h0 || {flag_c, flag_z, flag_n, flag_v} !== 4'b1101 || ovf_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL nosat_neg: result=%h flags=%b cnt=%0d expected 0 1101 3", result,
                     {flag_c, flag_z, flag_n, flag_v}, ovf_count);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure;
        step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h11, 1'b0, 1'b0));
        step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h22, 1'b0, 1'b0));
        tests_run++;
        if (in_ready !== 1'b0 || result !== 32'h11) begin
            tests_failed++;
            $display("FAIL bp_full: in_ready=%b result=%h expected 0 11", in_ready, result);
        end
        step(1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h99, 1'b0, 1'b0));
        tests_run++;
        if (in_ready !== 1'b0 || result !== 32'h11 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_hold: in_ready=%b result=%h valid=%b expected 0 11 1", in_ready, result,
                     out_valid);
        end
        idle(1'b1);
        tests_run++;
        if (result !== 32'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_second: result=%h valid=%b in_ready=%b expected 22 1 1", result, out_valid,
                     in_ready);
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: out_valid=%b expected 0 (third input must be dropped)", out_valid);
        end
    endtask

    task automatic test_push_pop;
        step(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h33, 1'b0, 1'b0));
        step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h44, 1'b0, 1'b0));
        tests_run++;
        if (result !== 32'h44 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL pushpop: result=%h valid=%b in_ready=%b expected 44 1 1", result, out_valid,
                     in_ready);
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL pushpop_dup: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_counter;
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mk(32'h0, 1'b0, 1'b0));
        for (int i = 0; i < 65537; i++)
            step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        tests_run++;
        if (ovf_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL cnt_sat: ovf_count=%h expected ffff", ovf_count);
        end
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        tests_run++;
        if (ovf_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL cnt_clr_prio: ovf_count=%h expected 0", ovf_count);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid;
        step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h66, 1'b0, 1'b0));
        reset = 1'b1; in_valid = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_ready: in_ready=%b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || ovf_count !== 16'd0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid: valid=%b cnt=%0d in_ready=%b expected 0 0 0", out_valid, ovf_count,
                     in_ready);
        end
        reset = 1'b0; in_valid = 1'b0;
        mq.delete(); mcnt = 0;
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h77, 1'b0, 1'b0));
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'h77) begin
            tests_failed++;
            $display("FAIL rst_mid_new: valid=%b result=%h expected 1 77", out_valid, result);
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_stale: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, s, r;
        logic        co, v, se;
        longint      st;
        int          errs;
        errs = 0;
        for (int i = 0; i < 3000; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 9) == 0) begin a = 32'd0; b = 32'd0; end
            if ($urandom_range(0, 9) == 1) b = -a;
            {co, s} = {1'b0, a} + {1'b0, b};
            st = longint'($signed(a)) + longint'($signed(b));
            v  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
            se = 1'($urandom_range(0, 1));
            r  = (v && se) ? ((st > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : s;
            step(1'($urandom_range(0, 3) != 0), s, co, a[31], b[31], se,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0), mk(r, co, v));
            tests_run++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) || ovf_count !== 16'(mcnt)) begin
                tests_failed++;
                if (errs++ < 10)
                    $display("FAIL rand_ctrl[%0d]: valid=%b ready=%b cnt=%0d expected %b %b %0d", i,
                             out_valid, in_ready, ovf_count, mq.size() > 0, mq.size() < 2, mcnt);
            end
            if (mq.size() > 0) begin
                tests_run++;
                if (result !== mq[0].r || {flag_c, flag_z, flag_n, flag_v} !==
                    {mq[0].c, mq[0].z, mq[0].n, mq[0].v}) begin
                    tests_failed++;
                    if (errs++ < 10)
                        $display("FAIL rand_data[%0d]: result=%h flags=%b expected %h %b", i, result,
                                 {flag_c, flag_z, flag_n, flag_v}, mq[0].r,
                                 {mq[0].c, mq[0].z, mq[0].n, mq[0].v});
                end
            end
        end
        idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_counter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
